fetch_unit: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 34 +++
 rtl/if_id_latch.sv | 33 +++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined RISC-V core: machine word, fetch FSM states
// and the IF/ID pipeline record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // addi x0,x0,0
  localparam word_t NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    HALTED
  } fetch_state_t;

  // Also used as the fetch hold buffer.
  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
    logic  valid;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Port bundle for the fetch unit: the fu side is the design, the tb side
// drives the core-facing inputs and observes IF/ID.
interface fetch_unit_if
  import cpu_types_pkg::*;
(
  input logic CLK
);

  logic  nRST;
  logic  ihit;
  word_t imemload;
  logic  stall;
  logic  flush;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  logic  imemREN;
  word_t imemaddr;
  word_t instr;
  word_t pc_out;
  word_t npc_out;
  logic  valid;

  modport fu (
    input  CLK, nRST, ihit, imemload, stall, flush, redirect, redirect_pc, halt,
    output imemREN, imemaddr, instr, pc_out, npc_out, valid
  );

  modport tb (
    input  CLK, imemREN, imemaddr, instr, pc_out, npc_out, valid,
    output nRST, ihit, imemload, stall, flush, redirect, redirect_pc, halt
  );

endinterface

// File: rtl/if_id_latch.sv
// IF/ID pipeline register. bubble has priority over load; squash clears only
// the valid bit and leaves the last word in place.
module if_id_latch
  import cpu_types_pkg::*;
#(
  parameter word_t NOP_INSTR = cpu_types_pkg::NOP_INSTR
) (
  input  logic   CLK,
  input  logic   nRST,
  input  logic   load,
  input  logic   bubble,
  input  logic   squash,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q.instr <= NOP_INSTR;
      q.pc    <= '0;
      q.npc   <= '0;
      q.valid <= 1'b0;
    end else if (bubble) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end else if (squash) begin
      q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, icache request handshake, one-entry hold
// buffer for words returned under stall, and the IF/ID latch.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0000_0000,
  parameter word_t NOP_INSTR = cpu_types_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic        valid
);

  fetch_state_t state;
  word_t        pc;
  word_t        pc_plus4;
  if_id_t       hbuf;
  if_id_t       fetched;
  if_id_t       ifid_d;
  if_id_t       ifid_q;
  logic         ifid_load;
  logic         ifid_bubble;
  logic         ifid_squash;

  assign pc_plus4 = pc + 32'd4;
  assign fetched  = '{instr: imemload, pc: pc, npc: pc_plus4, valid: 1'b1};

  assign imemaddr = pc;
  assign imemREN  = (state == FETCH);

  // IF/ID controls follow the same priority chain as the state update below.
  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_squash = 1'b0;
    ifid_d      = hbuf;
    if (state != HALTED) begin
      if (halt || redirect || flush) begin
        ifid_bubble = 1'b1;
      end else if (state == HOLD) begin
        ifid_load = !stall;
      end else if (!stall) begin
        if (ihit) begin
          ifid_load = 1'b1;
          ifid_d    = fetched;
        end else begin
          ifid_squash = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH;
      pc    <= PC_INIT;
      hbuf  <= '0;
    end else if (state != HALTED) begin
      if (halt) begin
        state <= HALTED;
        hbuf  <= '0;
      end else if (redirect) begin
        state <= FETCH;
        pc    <= redirect_pc;
        hbuf  <= '0;
      end else if (flush) begin
        // Rewind to the squashed buffered word so it is fetched again.
        if (state == HOLD) begin
          pc <= hbuf.pc;
        end
        state <= FETCH;
        hbuf  <= '0;
      end else if (state == HOLD) begin
        if (!stall) begin
          state <= FETCH;
          hbuf  <= '0;
        end
      end else if (ihit) begin
        pc <= pc_plus4;
        if (stall) begin
          state <= HOLD;
          hbuf  <= fetched;
        end
      end
    end
  end

  if_id_latch #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .CLK   (CLK),
    .nRST  (nRST),
    .load  (ifid_load),
    .bubble(ifid_bubble),
    .squash(ifid_squash),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign instr   = ifid_q.instr;
  assign pc_out  = ifid_q.pc;
  assign npc_out = ifid_q.npc;
  assign valid   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  localparam word_t NOP = 32'h0000_0013;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  fetch_unit_if fif (.CLK(CLK));

  fetch_unit #(
    .PC_INIT  (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK        (CLK),
    .nRST       (fif.nRST),
    .ihit       (fif.ihit),
    .imemload   (fif.imemload),
    .stall      (fif.stall),
    .flush      (fif.flush),
    .redirect   (fif.redirect),
    .redirect_pc(fif.redirect_pc),
    .halt       (fif.halt),
    .imemREN    (fif.imemREN),
    .imemaddr   (fif.imemaddr),
    .instr      (fif.instr),
    .pc_out     (fif.pc_out),
    .npc_out    (fif.npc_out),
    .valid      (fif.valid)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: a queue holds at most one word fetched while stalled.
  typedef struct {
    word_t w;
    word_t pc;
  } pend_t;

  word_t m_pc, m_instr, m_pcout, m_npc;
  bit    m_valid, m_halted;
  pend_t m_buf[$];

  function automatic void model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcout = 32'h0; m_npc = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_buf.delete();
  endfunction

  function automatic void model_step(bit ih, word_t w, bit st, bit fl, bit rd,
                                     word_t rpc, bit hl);
    pend_t p;
    if (m_halted) return;
    if (hl) begin
      m_halted = 1'b1; m_instr = NOP; m_valid = 1'b0; m_buf.delete();
    end else if (rd) begin
      m_pc = rpc; m_instr = NOP; m_valid = 1'b0; m_buf.delete();
    end else if (fl) begin
      if (m_buf.size() > 0) m_pc = m_buf[0].pc;
      m_instr = NOP; m_valid = 1'b0; m_buf.delete();
    end else if (m_buf.size() > 0) begin
      if (!st) begin
        p = m_buf.pop_front();
        m_instr = p.w; m_pcout = p.pc; m_npc = p.pc + 32'd4; m_valid = 1'b1;
      end
    end else if (ih) begin
      if (st) begin
        p.w = w; p.pc = m_pc; m_buf.push_back(p);
      end else begin
        m_instr = w; m_pcout = m_pc; m_npc = m_pc + 32'd4; m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_valid = 1'b0;
    end
  endfunction

  // Drives one cycle of inputs, advances the model, samples #1 after the edge.
  task automatic cycle(bit ih, word_t w, bit st, bit fl, bit rd, word_t rpc, bit hl);
    fif.ihit = ih; fif.imemload = w; fif.stall = st; fif.flush = fl;
    fif.redirect = rd; fif.redirect_pc = rpc; fif.halt = hl;
    model_step(ih, w, st, fl, rd, rpc, hl);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    fif.nRST = 1'b0;
    fif.ihit = 0; fif.imemload = '0; fif.stall = 0; fif.flush = 0;
    fif.redirect = 0; fif.redirect_pc = '0; fif.halt = 0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (fif.imemaddr !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", fif.imemaddr, 32'h0); end
    checks++; if (fif.imemREN !== 1'b1) begin failures++; $display("FAIL reset_ren got=%b exp=1", fif.imemREN); end
    checks++; if (fif.instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", fif.instr, NOP); end
    checks++; if (fif.pc_out !== 32'h0 || fif.npc_out !== 32'h0) begin failures++; $display("FAIL reset_pcs got=%h/%h exp=0/0", fif.pc_out, fif.npc_out); end
    checks++; if (fif.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", fif.valid); end
    @(negedge CLK);
    fif.nRST = 1'b1;
    model_reset();
  endtask

  task automatic test_fetch_stream();
    cycle(1, 32'h00500093, 0, 0, 0, 0, 0);
    checks++; if (fif.instr !== 32'h00500093 || fif.pc_out !== 32'h0 || fif.npc_out !== 32'h4 || fif.valid !== 1'b1)
      begin failures++; $display("FAIL stream0 got=%h/%h/%h/%b exp=00500093/0/4/1", fif.instr, fif.pc_out, fif.npc_out, fif.valid); end
    checks++; if (fif.imemaddr !== 32'h4) begin failures++; $display("FAIL stream0_addr got=%h exp=4", fif.imemaddr); end
    cycle(1, 32'h00108113, 0, 0, 0, 0, 0);
    checks++; if (fif.instr !== 32'h00108113 || fif.pc_out !== 32'h4 || fif.npc_out !== 32'h8 || fif.valid !== 1'b1)
      begin failures++; $display("FAIL stream1 got=%h/%h/%h/%b exp=00108113/4/8/1", fif.instr, fif.pc_out, fif.npc_out, fif.valid); end
    checks++; if (fif.imemaddr !== 32'h8) begin failures++; $display("FAIL stream1_addr got=%h exp=8", fif.imemaddr); end
  endtask

  task automatic test_ihit_gap();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 32'hdeadbeef, 0, 0, 0, 0, 0);
      checks++; if (fif.imemaddr !== 32'h8 || fif.imemREN !== 1'b1 || fif.valid !== 1'b0)
        begin failures++; $display("FAIL gap%0d got=%h/%b/%b exp=8/1/0", i, fif.imemaddr, fif.imemREN, fif.valid); end
    end
  endtask

  task automatic test_stall_hold();
    cycle(1, 32'h00208193, 0, 0, 0, 0, 0);
    cycle(1, 32'h0031a233, 1, 0, 0, 0, 0);
    checks++; if (fif.imemREN !== 1'b0 || fif.imemaddr !== 32'h10)
      begin failures++; $display("FAIL hold_enter got=%b/%h exp=0/10", fif.imemREN, fif.imemaddr); end
    checks++; if (fif.instr !== 32'h00208193 || fif.pc_out !== 32'h8 || fif.valid !== 1'b1)
      begin failures++; $display("FAIL hold_ifid got=%h/%h/%b exp=00208193/8/1", fif.instr, fif.pc_out, fif.valid); end
    cycle(1, 32'h11111111, 1, 0, 0, 0, 0);
    checks++; if (fif.imemREN !== 1'b0 || fif.imemaddr !== 32'h10 || fif.instr !== 32'h00208193)
      begin failures++; $display("FAIL hold_stay got=%b/%h/%h exp=0/10/00208193", fif.imemREN, fif.imemaddr, fif.instr); end
    cycle(0, 32'h0, 0, 0, 0, 0, 0);
    checks++; if (fif.instr !== 32'h0031a233 || fif.pc_out !== 32'hC || fif.npc_out !== 32'h10 || fif.valid !== 1'b1)
      begin failures++; $display("FAIL hold_release got=%h/%h/%h/%b exp=0031a233/c/10/1", fif.instr, fif.pc_out, fif.npc_out, fif.valid); end
    checks++; if (fif.imemREN !== 1'b1 || fif.imemaddr !== 32'h10)
      begin failures++; $display("FAIL hold_resume got=%b/%h exp=1/10", fif.imemREN, fif.imemaddr); end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 4; i++) cycle(1, 32'h00000513 + i, 0, 0, 0, 0, 0);
    checks++; if (fif.imemaddr !== 32'h20) begin failures++; $display("FAIL redir_pre got=%h exp=20", fif.imemaddr); end
    cycle(1, 32'hbad00bad, 1, 0, 1, 32'h100, 0);
    checks++; if (fif.instr !== NOP || fif.valid !== 1'b0 || fif.imemaddr !== 32'h100 || fif.imemREN !== 1'b1)
      begin failures++; $display("FAIL redir got=%h/%b/%h/%b exp=13/0/100/1", fif.instr, fif.valid, fif.imemaddr, fif.imemREN); end
    cycle(1, 32'h06400593, 0, 0, 0, 0, 0);
    checks++; if (fif.instr !== 32'h06400593 || fif.pc_out !== 32'h100 || fif.valid !== 1'b1)
      begin failures++; $display("FAIL redir_target got=%h/%h/%b exp=06400593/100/1", fif.instr, fif.pc_out, fif.valid); end
  endtask

  task automatic test_flush();
    cycle(0, 32'h0, 0, 0, 1, 32'h40, 0);
    cycle(1, 32'h00c58633, 1, 0, 0, 0, 0);
    checks++; if (fif.imemREN !== 1'b0 || fif.imemaddr !== 32'h44)
      begin failures++; $display("FAIL flush_hold got=%b/%h exp=0/44", fif.imemREN, fif.imemaddr); end
    cycle(0, 32'h0, 1, 1, 0, 0, 0);
    checks++; if (fif.instr !== NOP || fif.valid !== 1'b0 || fif.imemaddr !== 32'h40 || fif.imemREN !== 1'b1)
      begin failures++; $display("FAIL flush_in_hold got=%h/%b/%h/%b exp=13/0/40/1", fif.instr, fif.valid, fif.imemaddr, fif.imemREN); end
    cycle(1, 32'h00c58633, 0, 0, 0, 0, 0);
    checks++; if (fif.instr !== 32'h00c58633 || fif.pc_out !== 32'h40 || fif.imemaddr !== 32'h44)
      begin failures++; $display("FAIL flush_refetch got=%h/%h/%h exp=00c58633/40/44", fif.instr, fif.pc_out, fif.imemaddr); end
    cycle(1, 32'hcafef00d, 0, 1, 0, 0, 0);
    checks++; if (fif.instr !== NOP || fif.valid !== 1'b0 || fif.imemaddr !== 32'h44)
      begin failures++; $display("FAIL flush_fetch got=%h/%b/%h exp=13/0/44", fif.instr, fif.valid, fif.imemaddr); end
  endtask

  task automatic test_wrap();
    cycle(0, 32'h0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    cycle(1, 32'h00000073, 0, 0, 0, 0, 0);
    checks++; if (fif.pc_out !== 32'hFFFF_FFFC || fif.npc_out !== 32'h0 || fif.imemaddr !== 32'h0)
      begin failures++; $display("FAIL wrap got=%h/%h/%h exp=fffffffc/0/0", fif.pc_out, fif.npc_out, fif.imemaddr); end
  endtask

  task automatic test_halt();
    word_t frozen;
    cycle(1, 32'h12345678, 0, 0, 0, 0, 0);
    frozen = fif.imemaddr;
    cycle(1, 32'h0badf00d, 0, 0, 0, 0, 1);
    checks++; if (fif.imemREN !== 1'b0 || fif.valid !== 1'b0 || fif.instr !== NOP || fif.imemaddr !== frozen)
      begin failures++; $display("FAIL halt got=%b/%b/%h/%h exp=0/0/13/%h", fif.imemREN, fif.valid, fif.instr, fif.imemaddr, frozen); end
    for (int i = 0; i < 5; i++) begin
      cycle(1, $urandom, i[0], i[1], 1, $urandom, 0);
      checks++; if (fif.imemREN !== 1'b0 || fif.valid !== 1'b0 || fif.imemaddr !== frozen)
        begin failures++; $display("FAIL halted%0d got=%b/%b/%h exp=0/0/%h", i, fif.imemREN, fif.valid, fif.imemaddr, frozen); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    #2 fif.nRST = 1'b0;
    #1;
    checks++; if (fif.imemaddr !== 32'h0 || fif.imemREN !== 1'b1 || fif.valid !== 1'b0 || fif.instr !== NOP)
      begin failures++; $display("FAIL async_reset got=%h/%b/%b/%h exp=0/1/0/13", fif.imemaddr, fif.imemREN, fif.valid, fif.instr); end
    fif.ihit = 0; fif.stall = 0; fif.flush = 0; fif.redirect = 0; fif.halt = 0;
    @(negedge CLK);
    fif.nRST = 1'b1;
    model_reset();
    cycle(1, 32'h00100093, 0, 0, 0, 0, 0);
    checks++; if (fif.instr !== 32'h00100093 || fif.pc_out !== 32'h0 || fif.valid !== 1'b1 || fif.imemaddr !== 32'h4)
      begin failures++; $display("FAIL post_reset got=%h/%h/%b/%h exp=00100093/0/1/4", fif.instr, fif.pc_out, fif.valid, fif.imemaddr); end
  endtask

  task automatic test_random();
    bit ih, st, fl, rd;
    for (int n = 0; n < 400; n++) begin
      ih = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 15) == 0);
      rd = ($urandom_range(0, 15) == 0);
      cycle(ih, $urandom, st, fl, rd, $urandom, 0);
      checks++; if (fif.imemaddr !== m_pc || fif.imemREN !== (m_buf.size() == 0))
        begin failures++; $display("FAIL rand_fetch n=%0d got=%h/%b exp=%h/%b", n, fif.imemaddr, fif.imemREN, m_pc, m_buf.size() == 0); end
      checks++; if (fif.instr !== m_instr || fif.valid !== m_valid)
        begin failures++; $display("FAIL rand_ifid n=%0d got=%h/%b exp=%h/%b", n, fif.instr, fif.valid, m_instr, m_valid); end
      if (m_valid) begin
        checks++; if (fif.pc_out !== m_pcout || fif.npc_out !== m_npc)
          begin failures++; $display("FAIL rand_pcs n=%0d got=%h/%h exp=%h/%h", n, fif.pc_out, fif.npc_out, m_pcout, m_npc); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_ihit_gap();
    test_stall_hold();
    test_redirect();
    test_flush();
    test_wrap();
    test_halt();
    test_async_reset();
    test_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
